// File: rtl/fifo_packetizer.sv
// Drains an upstream FIFO into framed packets: one header word (seq, len)
// followed by 1..MAX_LEN payload words, launched on a full packet or on timeout.
module fifo_packetizer #(
  parameter int aw      = 3,
  parameter int dw      = 32,
  parameter int fwft    = 0,
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] fifo_dout,
  output logic          fifo_re,
  input  logic          fifo_empty,
  input  logic [aw:0]   fifo_count,
  output logic [dw-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_first,
  output logic          m_last,
  output logic [15:0]   seq,
  output logic [15:0]   flush_cnt,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LW = aw + 1;

  logic [1:0]    state;
  logic          active;
  logic [TW-1:0] tcnt;
  logic [aw:0]   occ;
  logic [aw:0]   launch_len;
  logic [aw:0]   rem_rd;
  logic [aw:0]   rem_out;
  logic          full_hit;
  logic          time_hit;
  logic          launch;
  logic [dw-1:0] hdr_word;
  logic [dw-1:0] hdr_next;
  logic [dw-1:0] skid [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    skid_cnt;
  logic          in_flight;
  logic          cap;
  logic          pop;
  logic          in_pkt;
  logic [2:0]    fill;

  // Stream handshake: a beat transfers on a cycle with m_valid & m_ready; once
  // m_valid is high it stays high with m_data/m_first/m_last frozen until taken.

  assign occ        = fifo_empty ? '0 : fifo_count + LW'(1);
  assign full_hit   = occ >= LW'(MAX_LEN);
  assign time_hit   = (tcnt == TW'(TIMEOUT)) && (occ != '0);
  assign launch     = active && (state == S_IDLE) && (full_hit || time_hit);
  assign launch_len = full_hit ? LW'(MAX_LEN) : occ;

  assign in_pkt   = (state == S_HDR) || (state == S_BODY);
  assign m_valid  = (state == S_HDR) || ((state == S_BODY) && (skid_cnt != 2'd0));
  assign m_first  = (state == S_HDR);
  assign m_last   = (state == S_BODY) && (skid_cnt != 2'd0) && (rem_out == LW'(1));
  assign pop      = (state == S_BODY) && m_valid && m_ready;
  assign state_dbg = state;

  // Words already requested (buffered or still in flight) must fit in the
  // two-entry skid buffer once this cycle's pop is accounted for.
  assign fill    = {1'b0, skid_cnt} + {2'b0, in_flight} - {2'b0, pop};
  assign fifo_re = !fifo_empty &&
                   (launch || (in_pkt && (rem_rd != '0) && (fill < 3'd2)));
  assign cap     = (fwft != 0) ? fifo_re : in_flight;

  always_comb begin
    hdr_next = '0;
    hdr_next[dw-1 -: 16] = seq;
    hdr_next[15:0] = 16'(launch_len);
  end

  always_comb begin
    m_data = '0;
    if (state == S_HDR) begin
      m_data = hdr_word;
    end else if ((state == S_BODY) && (skid_cnt != 2'd0)) begin
      m_data = skid[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      active    <= 1'b0;
      tcnt      <= '0;
      rem_rd    <= '0;
      rem_out   <= '0;
      hdr_word  <= '0;
      seq       <= '0;
      flush_cnt <= '0;
      in_flight <= 1'b0;
      skid[0]   <= '0;
      skid[1]   <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      skid_cnt  <= '0;
    end else begin
      active <= 1'b1;

      case (state)
        S_IDLE:  if (launch) state <= S_HDR;
        S_HDR:   if (m_ready) state <= S_BODY;
        S_BODY:  if (pop && (rem_out == LW'(1))) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // The timeout only runs while idling on a non-empty FIFO.
      if ((state == S_IDLE) && !launch && !fifo_empty) begin
        if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end

      if (launch) begin
        hdr_word <= hdr_next;
        rem_out  <= launch_len;
        rem_rd   <= launch_len - LW'(fifo_re);
        if (!full_hit && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      end else begin
        if (fifo_re) rem_rd <= rem_rd - LW'(1);
        if (pop) rem_out <= rem_out - LW'(1);
      end

      if ((state == S_HDR) && m_ready) seq <= seq + 16'd1;

      in_flight <= (fwft == 0) && fifo_re;
      if (cap) begin
        skid[wr_ptr] <= fifo_dout;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      skid_cnt <= skid_cnt + {1'b0, cap} - {1'b0, pop};
    end
  end

endmodule

// File: doc/fifo_packetizer.md
Name: fifo_packetizer

Overview:
- Drains a genericFifo instance, which sits directly upstream, and emits framed packets on a valid/ready stream.
- Each packet is one header word followed by 1..MAX_LEN payload words.
- A packet is launched when the FIFO holds MAX_LEN words, or when data has waited TIMEOUT cycles.
- Handles FIFO read latency for both fwft=1 (data with re) and fwft=0 (data one cycle after re).

Parameters:
- aw, 3: address width of the upstream FIFO; fifo_count is aw+1 bits.
- dw, 32: data width; must be >= 32.
- fwft, 0: must match the upstream FIFO. 1 = dout valid in the re cycle; 0 = dout valid the cycle after re.
- MAX_LEN, 8: maximum payload words per packet; 1 <= MAX_LEN <= 2**aw.
- TIMEOUT, 255: idle cycles with data present before a partial packet is flushed; >= 1.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_dout  in  dw  FIFO read data.
- fifo_re  out  1  FIFO read enable.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  aw+1  FIFO count: occupancy-1, all-ones when empty (signed -1).
- m_data  out  dw  output word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_first  out  1  current beat is the header.
- m_last  out  1  current beat is the final payload word.
- seq  out  16  sequence number of the next packet.
- flush_cnt  out  16  number of packets launched by timeout (saturating).

Behaviour:
- Reset (async assert, sync release) clears everything: fifo_re=0, m_valid=0, m_data=0, m_first=0, m_last=0, seq=0, flush_cnt=0. State goes to IDLE; timeout counter, skid buffer and in-flight flag are cleared.
- Occupancy: occ = fifo_empty ? 0 : fifo_count+1, computed in aw+1 bits unsigned.
- IDLE:
  - Timeout counter tcnt increments each cycle while fifo_empty=0; it is held at 0 while empty.
  - Launch when occ >= MAX_LEN, or when tcnt == TIMEOUT with occ >= 1.
  - On launch: latch len = min(occ, MAX_LEN) and rem_rd = len; clear tcnt; go to HDR.
  - flush_cnt increments only when the launch was by timeout and occ < MAX_LEN.
- HDR:
  - Header word is loaded into the output buffer. Bits [dw-1:dw-16] = seq, bits [15:0] = len, other bits 0. m_first=1.
  - Payload reads may start in the same cycle as the header load.
  - When the header is accepted (m_valid & m_ready), seq increments (wraps at 16 bits) and the state goes to BODY.
- BODY:
  - fifo_re = 1 when rem_rd > 0 and (buffered + in_flight - pop) < 2.
  - buffered is the 2-entry skid buffer occupancy. in_flight is 1 for fwft=0 after a re; pop = m_valid & m_ready.
  - rem_rd decrements on each re; the block never reads more than len words.
  - Data capture: fwft=1 captures fifo_dout in the re cycle; fwft=0 captures it the cycle after re.
  - Words are emitted in FIFO order. m_last=1 on the len-th payload beat.
  - Acceptance of the last beat returns the state to IDLE. tcnt restarts from 0 there, even if the FIFO is non-empty.
- Throughput: with m_ready held at 1, the stream runs header + len payload beats back-to-back with no bubbles, for either fwft setting.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_first and m_last are held stable, and m_valid is not deasserted.
- Sole reader: fifo_re is never asserted when fifo_empty=1. The FIFO has no other reader, so the latched len is always available; writes during a packet only raise occupancy.
- Simultaneous events:
  - A write arriving in the launch cycle is not counted in len; it goes to the next packet.
  - tcnt == TIMEOUT coinciding with occ reaching MAX_LEN launches a full packet; flush_cnt does not increment.
- Reset mid-packet: everything is aborted and nothing further is emitted. The FIFO is not drained or rewound; remaining data forms fresh packets after reset.
- flush_cnt saturates at 16'hFFFF.

Test Plan:
- MAX_LEN=8, fwft=0, m_ready=1; write 8 words 0x10..0x17 back-to-back -> header 0x00000008 (seq 0), then 0x10..0x17 on 9 consecutive m_valid beats; m_first on beat 0, m_last on beat 8; seq becomes 1.
- Write 3 words, then idle -> launch exactly TIMEOUT cycles after the FIFO goes non-empty; header 0x00010003, 3 payload words; flush_cnt=1.
- Write 20 words continuously -> packets of lengths 8, 8, then 4 after timeout; seq 0,1,2; no loss or duplication; fifo_re never asserted while empty.
- Random m_ready at 50% over 1000 words -> scoreboard matches input order; m_data stable while stalled; number of reads equals the sum of header lengths.
- Deassert rst_n mid-BODY (at word 3 of 8) -> all outputs 0 immediately; after release, the remaining FIFO words come out as a new packet with seq 0.
- Repeat the first and fourth scenarios with fwft=1 -> identical output streams, with no bubbles when m_ready=1.
